// File: rtl/div_seq_if.sv
// Bus bundle for the sequential signed divider: operands and control in,
// registered result and status flags out.
interface div_seq_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        init;
  logic        stop;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output a, b, init, stop,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  a, b, init, stop,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/div_seq.sv
// 32-bit signed restoring divider, one quotient bit per clock, truncating
// semantics (remainder carries the dividend sign).
//
//   state | meaning
//   IDLE  | waiting for init; b == 0 gives a div_zero pulse and no start
//   RUN   | 32 restoring shift/subtract steps on the operand magnitudes
//   FIX   | apply signs, write hi/lo, pulse done
module div_seq (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] bmag_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        div_zero_q;

  logic [31:0] amag_d;
  logic [31:0] bmag_d;
  logic [32:0] shifted_d;
  logic [32:0] trial_d;
  logic [31:0] rem_d;
  logic        qbit_d;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign amag_d = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
  assign bmag_d = bus.b[31] ? (~bus.b + 32'd1) : bus.b;

  assign shifted_d = {rem_q, quo_q[31]};
  assign trial_d   = shifted_d - {1'b0, bmag_q};
  assign qbit_d    = ~trial_d[32];
  assign rem_d     = trial_d[32] ? shifted_d[31:0] : trial_d[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      bmag_q     <= 32'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      if (bus.stop) begin
        state_q   <= IDLE;
        cnt_q     <= 6'd0;
        rem_q     <= 32'd0;
        quo_q     <= 32'd0;
        bmag_q    <= 32'd0;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
        hi_q      <= 32'd0;
        lo_q      <= 32'd0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.init) begin
              if (bus.b == 32'd0) begin
                div_zero_q <= 1'b1;
              end else begin
                quo_q     <= amag_d;
                bmag_q    <= bmag_d;
                rem_q     <= 32'd0;
                neg_quo_q <= bus.a[31] ^ bus.b[31];
                neg_rem_q <= bus.a[31];
                cnt_q     <= 6'd32;
                busy_q    <= 1'b1;
                state_q   <= RUN;
              end
            end
          end
          RUN: begin
            rem_q <= rem_d;
            quo_q <= {quo_q[30:0], qbit_d};
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) state_q <= FIX;
          end
          FIX: begin
            lo_q    <= neg_quo_q ? (~quo_q + 32'd1) : quo_q;
            hi_q    <= neg_rem_q ? (~rem_q + 32'd1) : rem_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against a signed-arithmetic
// reference using 64-bit integer division.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_if bus();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Truncating signed division; 64-bit math makes min/-1 wrap naturally.
  function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    sa = $signed(av);
    sb = $signed(bv);
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  task automatic do_div(input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] eq, er;
    int cyc, nbusy;
    bit stable;
    if (bv != 32'd0) ref_div(av, bv, eq, er);
    else begin eq = m_lo; er = m_hi; end
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    if (bv == 32'd0) begin
      check("dz_pulse", 32'(bus.div_zero), 32'd1);
      check("dz_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("dz_single", 32'(bus.div_zero), 32'd0);
      check("dz_nodone", 32'(bus.done), 32'd0);
      check("dz_hi", bus.hi, m_hi);
      check("dz_lo", bus.lo, m_lo);
      return;
    end
    cyc = 0; nbusy = 0; stable = 1'b1;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) nbusy++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'd33);
    check("busy_len", 32'(nbusy), 32'd33);
    check("hold", 32'(stable), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("quo", bus.lo, eq);
    check("rem", bus.hi, er);
    m_hi = er;
    m_lo = eq;
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
  endtask

  task automatic start_then_wait(input logic [31:0] av, input logic [31:0] bv, input int n);
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_quiet(input string tag);
    int ndone;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    check(tag, 32'(ndone), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] av, bv;
    int cnt;
    rst = 1'b1;
    bus.init = 1'b0; bus.stop = 1'b0;
    bus.a = 32'd5; bus.b = 32'd3;
    #12;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dz", 32'(bus.div_zero), 32'd0);
    bus.init = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_noinit", 32'(bus.busy), 32'd0);
    bus.init = 1'b0;
    rst = 1'b0;

    do_div(32'd100, 32'd7);
    do_div(32'hFFFFFF9C, 32'd7);
    do_div(32'd100, 32'hFFFFFFF9);
    do_div(32'h80000000, 32'hFFFFFFFF);
    do_div(32'd100, 32'd7);
    do_div(32'd5, 32'd0);

    for (int i = 0; i < 12; i++) begin
      av = $urandom; bv = $urandom;
      case (i % 4)
        1: bv = 32'($urandom_range(1, 20));
        2: bv = ~32'($urandom_range(1, 20)) + 32'd1;
        3: av = 32'h80000000;
        default: ;
      endcase
      if (i == 5) bv = 32'd0;
      do_div(av, bv);
    end

    // synchronous abort mid-run
    do_div(32'd100, 32'd7);
    start_then_wait(32'd1000, 32'd3, 9);
    check("stop_pre_busy", 32'(bus.busy), 32'd1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_busy", 32'(bus.busy), 32'd0);
    check("stop_hi", bus.hi, 32'd0);
    check("stop_lo", bus.lo, 32'd0);
    check("stop_done", 32'(bus.done), 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    expect_quiet("stop_quiet");

    // asynchronous reset mid-run, checked before the next rising edge
    do_div(32'd100, 32'd7);
    start_then_wait(32'd1000, 32'd3, 9);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_hi", bus.hi, 32'd0);
    check("arst_lo", bus.lo, 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    expect_quiet("arst_quiet");

    // init held high: one result per 34 cycles
    @(negedge clk);
    bus.a = 32'd9; bus.b = 32'd2; bus.init = 1'b1;
    cnt = 0;
    while (!bus.done && cnt < 60) begin @(negedge clk); cnt++; end
    check("b2b_first", 32'(cnt), 32'd34);
    check("b2b_lo0", bus.lo, 32'd4);
    check("b2b_hi0", bus.hi, 32'd1);
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      @(negedge clk); cnt++;
      while (!bus.done && cnt < 60) begin @(negedge clk); cnt++; end
      check("b2b_period", 32'(cnt), 32'd34);
      check("b2b_lo", bus.lo, 32'd4);
      check("b2b_hi", bus.hi, 32'd1);
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.init = 1'b0;
    check("initstop_busy", 32'(bus.busy), 32'd0);
    check("initstop_lo", bus.lo, 32'd0);
    @(negedge clk);
    check("initstop_nostart", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
